// File: rtl/msg_stats_regs_if.sv
// Avalon-MM register-bus bundle. The slave modport is what a register bank
// sees: address/read/write/writedata in, readdata/readdatavalid out.
// Bus handshake: there is no waitrequest, so a transfer is accepted in the
// cycle read or write is sampled high; every accepted read is answered by
// exactly one readdatavalid pulse one cycle later, and readdata is only
// meaningful (and otherwise 0) while readdatavalid is high.
interface avalon_mm_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );
endinterface

// File: rtl/msg_stats_regs.sv
// Per-channel message statistics register bank on an Avalon-MM slave.
// Map (index i at ADDR_BASE + ADDR_STEP*i):
//   0 ID (RO), 1 CONTROL (RW), 2 OVERFLOW (W1C), 3 SCRATCH (RW),
//   4+c COUNTER c (read count, any write clears).
// Same-cycle priorities: counter clear beats increment, overflow set beats
// W1C, clear_all beats overflow set, reads always see pre-update state.
module msg_stats_regs #(
  parameter int ADDR_BASE    = 'h400,
  parameter int ADDR_STEP    = 'h2,
  parameter int NUM_CHANNELS = 4,
  parameter int COUNTER_SIZE = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] msg_enter,
  avalon_mm_if.slave              reg_mm,
  output logic                    irq
);

  localparam int         NUM_REGS = 4 + NUM_CHANNELS;
  localparam logic [7:0] VERSION  = 8'h02;

  logic                    count_en_q;
  logic                    irq_en_q;
  logic                    irq_en_d;
  logic [NUM_CHANNELS-1:0] ovf_q;
  logic [NUM_CHANNELS-1:0] ovf_d;
  logic [NUM_CHANNELS-1:0] ovf_set;
  logic [NUM_CHANNELS-1:0] w1c_mask;
  logic [DATA_WIDTH-1:0]   scratch_q;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic [COUNTER_SIZE-1:0] cnt_q [NUM_CHANNELS];
  logic [COUNTER_SIZE-1:0] cnt_d [NUM_CHANNELS];

  logic [31:0] addr_ext;
  logic [31:0] offset;
  logic [31:0] idx;
  logic        mapped;
  logic        wr_ctrl;
  logic        wr_ovf;
  logic        wr_scratch;
  logic        clear_all;

  // Address decode: an address is mapped only if it lands exactly on a
  // register slot at or above the base and within the register count.
  always_comb begin
    addr_ext = 32'(reg_mm.address);
    offset   = addr_ext - 32'(ADDR_BASE);
    idx      = offset / 32'(ADDR_STEP);
    mapped   = (addr_ext >= 32'(ADDR_BASE)) &&
               ((offset % 32'(ADDR_STEP)) == 32'd0) &&
               (idx < 32'(NUM_REGS));
  end

  assign wr_ctrl    = reg_mm.write && mapped && (idx == 32'd1);
  assign wr_ovf     = reg_mm.write && mapped && (idx == 32'd2);
  assign wr_scratch = reg_mm.write && mapped && (idx == 32'd3);
  assign clear_all  = wr_ctrl && reg_mm.writedata[1];
  assign w1c_mask   = wr_ovf ? reg_mm.writedata[NUM_CHANNELS-1:0] : '0;
  assign irq_en_d   = wr_ctrl ? reg_mm.writedata[2] : irq_en_q;

  // Read mux over the current (pre-write, pre-increment) register state.
  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (idx)
        32'd0:   rd_val = DATA_WIDTH'({VERSION, 8'(NUM_CHANNELS)});
        32'd1:   rd_val = DATA_WIDTH'({irq_en_q, 1'b0, count_en_q});
        32'd2:   rd_val = DATA_WIDTH'(ovf_q);
        32'd3:   rd_val = scratch_q;
        default: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (idx == 32'(4 + c)) rd_val = DATA_WIDTH'(cnt_q[c]);
          end
        end
      endcase
    end
  end

  // Counter and overflow next state, applying the clear/increment priorities.
  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clear_all || (reg_mm.write && mapped && (idx == 32'(4 + c)))) begin
        cnt_d[c] = '0;
      end else if (count_en_q && msg_enter[c]) begin
        if (&cnt_q[c]) begin
          ovf_set[c] = 1'b1;
          cnt_d[c]   = (SATURATE != 0) ? cnt_q[c] : '0;
        end else begin
          cnt_d[c] = cnt_q[c] + COUNTER_SIZE'(1);
        end
      end
    end
    ovf_d = clear_all ? '0 : ((ovf_q & ~w1c_mask) | ovf_set);
  end

  // State registers, read response and registered interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_en_q           <= 1'b1;
      irq_en_q             <= 1'b0;
      ovf_q                <= '0;
      scratch_q            <= '0;
      reg_mm.readdata      <= '0;
      reg_mm.readdatavalid <= 1'b0;
      irq                  <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      if (wr_ctrl)    count_en_q <= reg_mm.writedata[0];
      if (wr_scratch) scratch_q  <= reg_mm.writedata;
      irq_en_q             <= irq_en_d;
      ovf_q                <= ovf_d;
      reg_mm.readdatavalid <= reg_mm.read;
      reg_mm.readdata      <= reg_mm.read ? rd_val : '0;
      irq                  <= irq_en_d & (|ovf_d);
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

endmodule

// File: doc/msg_stats_regs.md
# msg_stats_regs

Parametrised Avalon-MM register bank for per-channel message statistics and debug access, the successor to the single-counter loopback register controller. Counts message-entry pulses on NUM_CHANNELS independent channels with selectable wrap or saturate behaviour and sticky overflow flags. It also provides a control register, a scratch register and an interrupt. It sits beside the datapath on the Qsys register bus.

## Interface
- ADDR_BASE, 'h400: bus address of register index 0; must match the Qsys assignment.
- ADDR_STEP, 'h2: address increment between consecutive register indices.
- NUM_CHANNELS, 4: number of counted channels; range 1..DATA_WIDTH.
- COUNTER_SIZE, 32: counter width; range 1..DATA_WIDTH.
- DATA_WIDTH, 32: bus data width; minimum 16.
- SATURATE, 0: counter overflow mode. 0 wraps to 0; 1 holds at all-ones.
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- msg_enter  in  NUM_CHANNELS  per-channel one-cycle event pulse; bit c increments counter c.
- reg_mm  avalon_mm_if.slave  -  uses address, read, write, writedata, readdata, readdatavalid.
- irq  out  1  level interrupt, registered.

## Operation
- Register index i lives at ADDR_BASE + ADDR_STEP*i. Any other address is unmapped.
- Index 0, ID (RO):
  - [7:0] = NUM_CHANNELS.
  - [15:8] = 8'h02 (version).
  - All other bits 0.
- Index 1, CONTROL (RW). Unused bits read 0.
  - bit0 count_en: reset 1. When 0, msg_enter is ignored.
  - bit1 clear_all: write-1 pulse that zeroes all counters and all overflow flags. Always reads 0.
  - bit2 irq_en: reset 0.
- Index 2, OVERFLOW (W1C):
  - bit c is set when counter c increments while at all-ones.
  - Writing 1 to bit c clears it. Writing 0 has no effect.
- Index 3, SCRATCH (RW): DATA_WIDTH bits, reset 0.
- Index 4+c, COUNTER c (c = 0..NUM_CHANNELS-1):
  - Read returns the count, zero-extended to DATA_WIDTH.
  - A write of any value clears that counter only. Its overflow bit is unaffected.
- Increment rule, when count_en=1 and msg_enter[c]=1:
  - Counter below all-ones: counter + 1.
  - At all-ones with SATURATE=0: counter becomes 0 and the overflow bit sets.
  - At all-ones with SATURATE=1: counter holds and the overflow bit sets.
- irq = irq_en & (|OVERFLOW).
- Writes to RO or unmapped addresses are ignored.
- Reads of unmapped addresses still return readdatavalid with readdata 0, so the master never hangs.
- Simultaneous events resolve as follows:
  - Counter clear (per-counter write or clear_all) and msg_enter in the same cycle: clear wins; the result is 0.
  - Overflow set and W1C clear of the same bit in the same cycle: set wins.
  - clear_all and an overflow in the same cycle: clear wins.
  - read and write in the same cycle to the same register: read returns the pre-write value, and the write takes effect.
  - Read of a counter in the same cycle as its increment: returns the pre-increment value.

## Timing
- Reset: while rst_n=0 at a clock edge, everything below is forced regardless of bus or msg_enter activity.
  - All counters, OVERFLOW, SCRATCH, readdata, readdatavalid and irq are 0.
  - CONTROL = 'b001.
- Reset mid-transaction: a read issued in the reset cycle gets no readdatavalid.
- No waitrequest. Every transfer is accepted in the cycle it is presented.
- Write effect: visible in register state on the next cycle.
  - A read in cycle N+1 returns data written in cycle N.
- Read latency is fixed at 1 cycle:
  - readdatavalid=1 with readdata in the cycle after read is sampled high.
  - Otherwise readdatavalid=0 and readdata=0.
- Back-to-back reads, one per cycle, are supported at full rate.
- Counter update: one increment per channel per cycle maximum.
  - Increment visible to a read issued in the cycle after the msg_enter pulse.
- irq: asserts the cycle after the overflow flag sets. Deasserts the cycle after a W1C clear or after irq_en is written 0.

## Test plan
- Reset, then read indices 0..3: returns 'h0204, 'h1, 'h0, 'h0 (NUM_CHANNELS=4). Each readdatavalid comes exactly 1 cycle after read.
- Pulse msg_enter=4'b0101 for 3 cycles, then read COUNTER0..3: returns 3, 0, 3, 0. Repeat with count_en=0: counts unchanged.
- COUNTER_SIZE=4, SATURATE=0, 17 pulses on ch1: COUNTER1=1, OVERFLOW='b0010. With irq_en=1, irq=1. Write OVERFLOW='b0010: irq=0 next cycle. With SATURATE=1: COUNTER1=15.
- Same-cycle write to COUNTER2 and msg_enter[2]=1: COUNTER2=0. Same-cycle W1C and new overflow on ch1: bit stays 1. Write CONTROL='b011: all counters and OVERFLOW read 0, and CONTROL reads 'b001.
- Write SCRATCH='hA5A5_5A5A, read next cycle: 'hA5A5_5A5A. Read address ADDR_BASE+'h100: readdatavalid=1, readdata=0. Write to ID: ID unchanged.
- Assert rst_n=0 for 1 cycle mid-sequence, with a read issued in the same cycle: no readdatavalid. All registers return reset values.
